if_stage_sramlike: RTL and testbench
====================================

Name: if_stage_sramlike

Overview:
Parametrised instruction-fetch stage for the MIPS pipeline. It replaces the fixed single-cycle SRAM fetch with an SRAM-like request/response bus (addr_ok/data_ok), which allows several in-flight fetches. It keeps a small instruction buffer in front of decode and cleanly cancels in-flight fetches on branch, exception and eret redirects. It sits between the instruction bus/cache and the decode stage and presents the standard 71-bit fs_to_ds bundle.

Parameters:
RESET_PC, 32'hbfc00000, first fetch address after reset
EX_VECTOR, 32'hbfc00380, fetch address on ws_ex
IBUF_DEPTH, 2, instruction buffer entries and the limit on (in-flight + buffered) fetches; must be 1..8
EXC_ADEL, 5'h04, excode for a misaligned fetch address

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ds_allowin  in  1  decode can accept an instruction this cycle
br_stall  in  1  decode cannot yet resolve a branch; hold new requests
br_taken  in  1  taken branch/jump resolved in decode (one-cycle pulse)
br_target  in  32  branch target, valid with br_taken
ds_is_branch  in  1  instruction in decode is a branch/jump (drives bd)
ws_ex  in  1  exception committed in writeback
ws_eret  in  1  eret committed in writeback
cp0_epc  in  32  return address for eret
fs_to_ds_valid  out  1  buffer head valid toward decode
fs_to_ds_bus  out  71  {bd[70], ex[69], excode[68:64], inst[63:32], pc[31:0]}
inst_req  out  1  bus request
inst_wr  out  1  constant 0
inst_size  out  2  constant 2'b10
inst_addr  out  32  request address
inst_wdata  out  32  constant 0
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data returned this cycle (responses are in order)
inst_rdata  in  32  read data

Behaviour:
- Reset:
  - fs_to_ds_valid=0, inst_req=0.
  - Next-PC register = RESET_PC.
  - Buffer, in-flight counter, discard counter and branch-pending flag all cleared.
- Issue:
  - inst_req rises when !reset, !br_stall, and inflight + buf_count < IBUF_DEPTH.
  - Once raised, inst_req and inst_addr stay stable until addr_ok.
  - On addr_ok: inflight += 1, the entry's pc is pushed to a pc FIFO, and npc advances.
- Next-PC priority, evaluated each cycle:
  - ws_ex → EX_VECTOR
  - ws_eret → cp0_epc
  - branch pending → latched target
  - otherwise npc + 4
- Branch:
  - br_taken && !br_stall latches br_target and sets br_pend.
  - Decode guarantees the delay-slot request has already been accepted.
  - The next accepted request uses the target and clears br_pend.
  - If a request is already being held (req=1, no addr_ok), it is allowed to complete and is marked discard. The target is issued next.
- Redirect on ws_ex or ws_eret in the same cycle:
  - Buffer flushed; br_pend cleared.
  - discard += inflight, plus 1 if a held request is accepted in that cycle or later.
  - fs_to_ds_valid is forced 0 that cycle.
- Response:
  - On data_ok, if discard>0: discard -= 1, inflight -= 1, and the data is dropped.
  - Otherwise push {inst_rdata, pc FIFO head} into the buffer and decrement inflight.
- Bypass: when the buffer is empty and ds_allowin=1, returning data goes straight to decode in the same cycle (zero-latency bypass).
- Address error:
  - npc[1:0]!=0 issues no bus request.
  - Instead it pushes an entry {ex=1, excode=EXC_ADEL, inst=0, pc=npc} once buffer space exists.
  - npc then stalls until a redirect arrives.
- Output:
  - fs_to_ds_valid = buffer head valid && !ws_ex && !ws_eret.
  - Pop when valid && ds_allowin.
  - bd = ds_is_branch, combinational.
  - ex/excode = 0 for normal entries.
- Boundaries:
  - A full buffer blocks issue; it never drops data.
  - Simultaneous push and pop keeps the count unchanged.
  - ws_ex has priority over ws_eret.
  - ws_ex and ws_eret override br_taken in the same cycle.
  - The pc FIFO and buffer pointers wrap modulo IBUF_DEPTH.
  - Reset mid-transaction clears all state. The bus must also be reset, so stale data_ok after reset is not handled.

Test Plan:
- Reset release, addr_ok and data_ok always 1, ds_allowin=1 → addresses bfc00000, bfc00004, bfc00008, …; fs_to_ds_valid the cycle data_ok returns with matching pc.
- ds_allowin=0 for 5 cycles, IBUF_DEPTH=2 → exactly 2 requests outstanding or buffered, inst_req stays 0 afterwards; release → both delivered in order, none lost.
- data_ok delayed 3 cycles with 2 in flight, ws_ex pulsed → both responses dropped; next inst_addr=bfc00380; first delivered pc=bfc00380.
- br_taken target=bfc00100 while delay slot bfc00004 is in flight → delivered pcs bfc00004 then bfc00100; bfc00008 is never requested, or is dropped if the request was already being held.
- ws_eret with cp0_epc=80000002 → no bus request; entry delivered with ex=1, excode=04, pc=80000002.
- inst_req held 4 cycles without addr_ok → inst_addr stable throughout; ws_eret mid-hold → that fetch is discarded on return and epc is fetched next.

Source files
------------

// File: rtl/if_stage_sramlike.sv
// Instruction-fetch stage for the MIPS pipeline on an SRAM-like request/response bus.
// Allows several fetches in flight, buffers returned instructions and drops wrong-path data after redirects.
module if_stage_sramlike #(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter logic [31:0] EX_VECTOR  = 32'hbfc00380,
  parameter int          IBUF_DEPTH = 2,
  parameter logic [4:0]  EXC_ADEL   = 5'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_is_branch,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  output logic        fs_to_ds_valid,
  output logic [70:0] fs_to_ds_bus,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int PW  = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW  = $clog2(IBUF_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(IBUF_DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(IBUF_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Fetch control state
  logic [31:0]   npc_reg;
  logic [31:0]   hold_addr_reg;
  logic [31:0]   br_tgt_reg;
  logic          hold_reg;
  logic          hold_drop_reg;
  logic          br_pend_reg;
  logic          adel_stall_reg;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] buf_count_reg;
  logic [CW-1:0] buf_count_next;

  // In-flight pc FIFO and instruction buffer
  logic [31:0]           pq_pc [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] pq_drop_reg;
  logic [IBUF_DEPTH-1:0] pq_drop_next;
  logic [PW-1:0]         pq_wr_reg;
  logic [PW-1:0]         pq_rd_reg;
  logic [31:0]           buf_inst [IBUF_DEPTH];
  logic [31:0]           buf_pc [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] buf_ex_reg;
  logic [IBUF_DEPTH-1:0] buf_ex_next;
  logic [PW-1:0]         buf_wr_reg;
  logic [PW-1:0]         buf_rd_reg;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        br_take;
  logic [31:0] fetch_pc;
  logic [CW:0] occupancy;
  logic        has_room;
  logic        fetch_ok;
  logic        new_req;
  logic        adel_push;
  logic        accept;
  logic        accept_drop;
  logic        resp;
  logic        resp_keep;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ex;
  logic        head_valid;
  logic        pop;
  logic        bypass;
  logic        push;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ex;

  assign redirect    = ws_ex | ws_eret;
  assign redirect_pc = ws_ex ? EX_VECTOR : cp0_epc;
  assign br_take     = br_taken & ~br_stall & ~redirect;
  assign fetch_pc    = br_pend_reg ? br_tgt_reg : npc_reg;
  assign occupancy   = {1'b0, inflight_reg} + {1'b0, buf_count_reg};
  assign has_room    = occupancy < DEPTH_W;

  // New fetches wait out redirect/branch cycles so the old path is never issued there.
  assign fetch_ok  = ~reset & ~hold_reg & ~adel_stall_reg & ~br_stall & ~redirect & ~br_take & has_room;
  assign new_req   = fetch_ok & (fetch_pc[1:0] == 2'b00);
  // Misaligned fetch becomes an exception entry, ordered behind everything still in flight.
  assign adel_push = fetch_ok & (fetch_pc[1:0] != 2'b00) & (inflight_reg == '0);

  assign inst_req    = ~reset & (hold_reg | new_req);
  assign inst_addr   = hold_reg ? hold_addr_reg : fetch_pc;
  assign inst_wr     = 1'b0;
  assign inst_size   = 2'b10;
  assign inst_wdata  = 32'd0;
  assign accept      = inst_req & inst_addr_ok;
  assign accept_drop = hold_reg & (hold_drop_reg | redirect | br_take);

  assign resp      = inst_data_ok & (inflight_reg != '0);
  assign resp_keep = resp & ~pq_drop_reg[pq_rd_reg] & ~redirect;
  assign in_valid  = resp_keep | adel_push;
  assign in_pc     = resp_keep ? pq_pc[pq_rd_reg] : fetch_pc;
  assign in_inst   = resp_keep ? inst_rdata : 32'd0;
  assign in_ex     = adel_push;

  assign head_valid = (buf_count_reg != '0);
  assign pop        = head_valid & ds_allowin & ~redirect;
  assign bypass     = ~head_valid & in_valid & ds_allowin;
  assign push       = in_valid & ~bypass;

  assign out_pc   = head_valid ? buf_pc[buf_rd_reg] : in_pc;
  assign out_inst = head_valid ? buf_inst[buf_rd_reg] : in_inst;
  assign out_ex   = head_valid ? buf_ex_reg[buf_rd_reg] : in_ex;

  assign fs_to_ds_valid = ~reset & (head_valid | in_valid) & ~redirect;
  assign fs_to_ds_bus   = {ds_is_branch, out_ex, (out_ex ? EXC_ADEL : 5'd0), out_inst, out_pc};

  for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_entry
    logic pq_we;
    logic buf_we;
    assign pq_we  = accept & (pq_wr_reg == PW'(gi));
    assign buf_we = push & (buf_wr_reg == PW'(gi));
    // A redirect kills every fetch still on the bus; a fresh entry takes its own flag.
    assign pq_drop_next[gi] = pq_we ? accept_drop : (pq_drop_reg[gi] | redirect);
    assign buf_ex_next[gi]  = buf_we ? in_ex : buf_ex_reg[gi];
  end

  always_comb begin
    inflight_next = inflight_reg;
    if (accept && !resp)      inflight_next = inflight_reg + 1'b1;
    else if (!accept && resp) inflight_next = inflight_reg - 1'b1;
  end

  always_comb begin
    buf_count_next = buf_count_reg;
    if (redirect)           buf_count_next = '0;
    else if (push && !pop)  buf_count_next = buf_count_reg + 1'b1;
    else if (!push && pop)  buf_count_next = buf_count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      npc_reg        <= RESET_PC;
      hold_addr_reg  <= '0;
      br_tgt_reg     <= '0;
      hold_reg       <= 1'b0;
      hold_drop_reg  <= 1'b0;
      br_pend_reg    <= 1'b0;
      adel_stall_reg <= 1'b0;
      inflight_reg   <= '0;
      buf_count_reg  <= '0;
      pq_drop_reg    <= '0;
      pq_wr_reg      <= '0;
      pq_rd_reg      <= '0;
      buf_ex_reg     <= '0;
      buf_wr_reg     <= '0;
      buf_rd_reg     <= '0;
    end else begin
      if (redirect) begin
        npc_reg        <= redirect_pc;
        br_pend_reg    <= 1'b0;
        adel_stall_reg <= 1'b0;
      end else begin
        if (br_take) begin
          br_pend_reg <= 1'b1;
          br_tgt_reg  <= br_target;
        end else if (new_req) begin
          npc_reg     <= fetch_pc + 32'd4;
          br_pend_reg <= 1'b0;
        end
        if (adel_push) adel_stall_reg <= 1'b1;
      end

      // Address stays frozen until the bus takes it; a killed hold still completes.
      if (inst_req && !inst_addr_ok) begin
        hold_reg      <= 1'b1;
        hold_addr_reg <= inst_addr;
        hold_drop_reg <= accept_drop;
      end else if (accept) begin
        hold_reg      <= 1'b0;
        hold_drop_reg <= 1'b0;
      end

      inflight_reg  <= inflight_next;
      buf_count_reg <= buf_count_next;
      pq_drop_reg   <= pq_drop_next;
      buf_ex_reg    <= buf_ex_next;
      if (accept) pq_wr_reg <= ptr_inc(pq_wr_reg);
      if (resp)   pq_rd_reg <= ptr_inc(pq_rd_reg);
      if (redirect) begin
        buf_wr_reg <= '0;
        buf_rd_reg <= '0;
      end else begin
        if (push) buf_wr_reg <= ptr_inc(buf_wr_reg);
        if (pop)  buf_rd_reg <= ptr_inc(buf_rd_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pq_pc[pq_wr_reg] <= inst_addr;
    if (push) begin
      buf_inst[buf_wr_reg] <= in_inst;
      buf_pc[buf_wr_reg]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_if_stage_sramlike.sv
// Directed bench for if_stage_sramlike: a small in-order bus model plus a scoreboard
// of instructions expected at decode, filled when the bus accepts an on-path fetch.
module tb_if_stage_sramlike;

  localparam logic [31:0] KEY = 32'h5a5a_0f0f;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } bus_t;

  typedef struct {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_is_branch;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] cp0_epc;
  logic        fs_to_ds_valid;
  logic [70:0] fs_to_ds_bus;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  if_stage_sramlike dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_stall(br_stall),
    .br_taken(br_taken), .br_target(br_target), .ds_is_branch(ds_is_branch),
    .ws_ex(ws_ex), .ws_eret(ws_eret), .cp0_epc(cp0_epc),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   lat = 1;
  bit   aok = 1'b1;
  bit   drop_accepts = 1'b0;
  bit   check_addr = 1'b1;
  bit   chk_bypass = 1'b0;
  int   deliveries = 0;
  int   req_seen = 0;
  logic [31:0] exp_addr = 32'hbfc00000;
  bus_t bus_q[$];
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_bus();
    inst_addr_ok = aok;
    if (bus_q.size() > 0 && bus_q[0].ready <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = bus_q[0].addr ^ KEY;
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
    end
    #1;
  endtask

  task automatic tick();
    exp_t e;
    bus_t b;
    ds_is_branch = cyc[0];
    drive_bus();
    if (inst_req) req_seen++;
    if (chk_bypass && inst_data_ok) chk("bypass_valid", 32'(fs_to_ds_valid), 32'd1);
    if (fs_to_ds_valid && ds_allowin) begin
      deliveries++;
      chk("deliver_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("deliver pc=%h inst=%h ex=%0d excode=%h", fs_to_ds_bus[31:0], fs_to_ds_bus[63:32], fs_to_ds_bus[69], fs_to_ds_bus[68:64]);
        chk("pc", fs_to_ds_bus[31:0], e.pc);
        chk("inst", fs_to_ds_bus[63:32], e.inst);
        chk("ex_excode", 32'(fs_to_ds_bus[69:64]), {26'd0, e.ex, e.excode});
        chk("bd", 32'(fs_to_ds_bus[70]), 32'(ds_is_branch));
      end
    end
    if (inst_data_ok) bus_q.delete(0);
    if (inst_req && inst_addr_ok) begin
      if (check_addr) begin
        chk("req_addr", inst_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      b.addr  = inst_addr;
      b.ready = cyc + lat;
      bus_q.push_back(b);
      if (!drop_accepts) begin
        e.ex = 1'b0; e.excode = 5'd0; e.inst = inst_addr ^ KEY; e.pc = inst_addr;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (deliveries < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(deliveries >= target), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_q.delete();
    exp_q.delete();
    tick();
    tick();
    drive_bus();
    chk("reset_req", 32'(inst_req), 32'd0);
    chk("reset_valid", 32'(fs_to_ds_valid), 32'd0);
    reset = 1'b0;
    exp_addr = 32'hbfc00000;
  endtask

  initial begin
    exp_t a;
    int d0;
    reset = 1'b1; ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0;
    br_target = 32'd0; ds_is_branch = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0;
    cp0_epc = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    @(negedge clk);
    drive_bus();
    chk("const_wr", 32'(inst_wr), 32'd0);
    chk("const_size", 32'(inst_size), 32'd2);
    chk("const_wdata", inst_wdata, 32'd0);

    // Sequential fetch with one-cycle bus, bypass to decode
    do_reset();
    chk_bypass = 1'b1;
    run_until(6, 40, "t1_stream");
    chk_bypass = 1'b0;

    // Decode stalls: fetch fills up to the depth limit, then releases in order
    ds_allowin = 1'b0;
    tick();
    tick();
    req_seen = 0;
    repeat (3) tick();
    chk("t2_req_idle", 32'(req_seen), 32'd0);
    chk("t2_outstanding", 32'(exp_q.size()), 32'd2);
    ds_allowin = 1'b1;
    run_until(deliveries + 2, 20, "t2_release");

    // Exception while two slow fetches are in flight
    do_reset();
    lat = 3;
    drop_accepts = 1'b1;
    tick();
    tick();
    drive_bus();
    chk("t3_full_no_req", 32'(inst_req), 32'd0);
    ws_ex = 1'b1;
    drive_bus();
    chk("t3_ex_valid", 32'(fs_to_ds_valid), 32'd0);
    tick();
    ws_ex = 1'b0;
    drop_accepts = 1'b0;
    exp_addr = 32'hbfc00380;
    run_until(deliveries + 2, 30, "t3_vector");

    // Taken branch with the delay slot still on the bus
    do_reset();
    lat = 2;
    tick();
    tick();
    drive_bus();
    chk("t4_full_no_req", 32'(inst_req), 32'd0);
    br_taken = 1'b1;
    br_target = 32'hbfc00100;
    tick();
    br_taken = 1'b0;
    exp_addr = 32'hbfc00100;
    run_until(deliveries + 4, 30, "t4_branch");

    // eret to a misaligned epc raises an address-error entry, never a bus request
    exp_q.delete();
    check_addr = 1'b0;
    drop_accepts = 1'b1;
    ws_eret = 1'b1;
    cp0_epc = 32'h80000002;
    tick();
    ws_eret = 1'b0;
    drop_accepts = 1'b0;
    a.ex = 1'b1; a.excode = 5'h04; a.inst = 32'd0; a.pc = 32'h80000002;
    exp_q.push_back(a);
    req_seen = 0;
    run_until(deliveries + 1, 20, "t5_adel");
    repeat (3) tick();
    chk("t5_no_req", 32'(req_seen), 32'd0);

    // Held request: ws_ex beats ws_eret, then an eret during the hold kills the fetch
    aok = 1'b0;
    exp_q.delete();
    ws_ex = 1'b1;
    ws_eret = 1'b1;
    tick();
    ws_ex = 1'b0;
    ws_eret = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        ws_eret = 1'b1;
        cp0_epc = 32'h80001000;
      end
      drive_bus();
      chk("t6_hold_req", 32'(inst_req), 32'd1);
      chk("t6_hold_addr", inst_addr, 32'hbfc00380);
      tick();
      ws_eret = 1'b0;
    end
    aok = 1'b1;
    drop_accepts = 1'b1;
    check_addr = 1'b1;
    exp_addr = 32'hbfc00380;
    tick();
    drop_accepts = 1'b0;
    exp_addr = 32'h80001000;
    d0 = deliveries;
    run_until(d0 + 2, 30, "t6_epc");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
